fifo_sync_top: RTL and testbench
================================

// Module: fifo_sync_top
// PURPOSE
// - Single-clock 16-entry x 8-bit first-in first-out buffer between a byte producer and a byte consumer.
// - Top-level FIFO of the subsystem: storage array, binary read/write pointers, occupancy counter, status flags.
// - Overflow and underflow requests are rejected; an accepted write is never lost.
// PARAMETERS
// - WIDTH  8   data word width in bits
// - DEPTH  16  number of storage entries; power of two, >= 2
// - AW     $clog2(DEPTH)  pointer width (localparam, derived)
// PORTS
// - wr_clk     in   1        sole clock, rising edge; drives write and read sides
// - wr_rst     in   1        asynchronous, active-high reset of the whole block
// - push       in   1        write request; data_in sampled on the same edge
// - data_in    in   WIDTH    write data
// - pop        in   1        read request
// - data_out   out  WIDTH    read data, registered
// - full       out  1        count == DEPTH
// - empty      out  1        count == 0
// - count      out  AW+1     current occupancy, 0..DEPTH
// BEHAVIOUR
// - Reset (asynchronous assert; release synchronous to wr_clk):
//   - wr_ptr = rd_ptr = 0, count = 0, data_out = 0.
//   - empty = 1, full = 0.
//   - Storage contents are not cleared.
// - Accept rules, evaluated on each rising edge:
//   - wr_ok = push & (~full | pop)
//   - rd_ok = pop & ~empty
// - Write: when wr_ok, mem[wr_ptr] <= data_in and wr_ptr increments, wrapping DEPTH-1 -> 0.
// - Read:
//   - When rd_ok, data_out <= mem[rd_ptr] and rd_ptr increments with the same wrap.
//   - Read latency is 1 cycle: data_out is valid on the edge after the pop edge.
//   - data_out holds its value when rd_ok = 0.
// - count: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
// - full and empty are combinational decodes of the registered count, so they update on the edge that changes count.
// - Push while full with no pop: ignored; storage, pointers and count unchanged.
// - Pop while empty: ignored; data_out holds its last value; pointers unchanged.
// - Push + pop while empty: the write is accepted, the read is rejected (no bypass); count 0 -> 1.
// - Push + pop while full: both accepted.
//   - data_out receives the oldest entry.
//   - The new word is stored in the freed slot; count stays DEPTH.
// - Push + pop at an intermediate level: both accepted; count unchanged.
// - Reset asserted mid-operation: state clears immediately, regardless of the clock.
// CONFIGURATION
// - Macro FIFO_ERR_FLAGS_EN.
// - Defined: extra outputs ovf_err (1) and udf_err (1).
//   - ovf_err is set on any push & full & ~pop edge.
//   - udf_err is set on any pop & empty edge.
//   - Both are sticky until wr_rst and reset to 0.
// - Undefined: neither port nor its logic exists; all other behaviour is identical.
// TESTING
// - Reset: pulse wr_rst -> empty=1, full=0, count=0, data_out=0.
// - Fill: push 0x01..0x10 on 16 consecutive edges.
//   - Result: full=1, count=16.
//   - A 17th push of 0xAA is ignored (ovf_err=1 when enabled).
// - Drain: pop 16 times -> data_out sequence 0x01..0x10, each 1 cycle after its pop; then empty=1.
//   - A 17th pop leaves data_out=0x10 (udf_err=1 when enabled).
// - Wrap-around: three rounds of push 10 / pop 10 with distinct bytes -> FIFO order preserved across pointer wrap.
// - Simultaneous ops:
//   - With count=16, push 0x55 + pop -> oldest word out, count stays 16, 0x55 read last.
//   - With count=0, push + pop -> count=1.
// - Mid-operation reset: with count=7, assert wr_rst between edges -> count=0 and empty=1 immediately; next push/pop behave normally.

Source files
------------

// File: rtl/fifo_sync_top.sv
// Single-clock 16 x 8 FIFO with binary pointers, an occupancy counter and
// status flags decoded from that counter. Writes into a full FIFO are dropped
// unless a read frees a slot on the same edge; reads from an empty FIFO are dropped.
// Optional sticky overflow/underflow flags: define FIFO_ERR_FLAGS_EN.
module fifo_sync_top #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     wr_clk,
  input  logic                     wr_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                     ovf_err,
  output logic                     udf_err
`else
  // no error-flag ports in this build
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CountMax = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_data_out;

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [AW:0]      w_count_d;

  // Flags are pure decodes of the registered count.
  assign full     = (r_count == CountMax);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign data_out = r_data_out;

  // A pop on a full FIFO frees the slot the push will reuse, so the push is accepted.
  // No bypass: a push+pop on an empty FIFO only writes.
  assign w_wr_ok = push & (~full | pop);
  assign w_rd_ok = pop & ~empty;

  // Next occupancy: net change of accepted write and read.
  always_comb begin
    w_count_d = r_count;
    unique case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_d = r_count + (AW+1)'(1);
      2'b01:   w_count_d = r_count - (AW+1)'(1);
      default: w_count_d = r_count;
    endcase
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge wr_clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_d;
    end
  end

  // Registered read data; holds when no read is accepted. When full, the old
  // word at rd_ptr is read before the simultaneous write replaces it.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_data_out <= '0;
    end else if (w_rd_ok) begin
      r_data_out <= r_mem[r_rd_ptr];
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_ovf_err;
  logic r_udf_err;

  assign ovf_err = r_ovf_err;
  assign udf_err = r_udf_err;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      if (push & full & ~pop) r_ovf_err <= 1'b1;
      if (pop & empty)        r_udf_err <= 1'b1;
    end
  end
`else
  // error flags not built
`endif

endmodule

// File: tb/tb_fifo_sync_top.sv
// Directed bench for fifo_sync_top: reset, fill/overflow, drain/underflow,
// pointer wrap, simultaneous push/pop at full and empty, mid-operation reset.
module tb_fifo_sync_top;

  logic       wr_clk  = 1'b0;
  logic       wr_rst  = 1'b1;
  logic       push    = 1'b0;
  logic       pop     = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic [4:0] count;
`ifdef FIFO_ERR_FLAGS_EN
  logic       ovf_err;
  logic       udf_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  fifo_sync_top #(
    .WIDTH(8),
    .DEPTH(16)
  ) u_dut (
    .wr_clk  (wr_clk),
    .wr_rst  (wr_rst),
    .push    (push),
    .data_in (data_in),
    .pop     (pop),
    .data_out(data_out),
    .full    (full),
    .empty   (empty),
    .count   (count)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .ovf_err (ovf_err),
    .udf_err (udf_err)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one edge worth of requests, then sample 1 time unit after the edge.
  task automatic cycle(input logic p, input logic [7:0] d, input logic q);
    push    = p;
    data_in = d;
    pop     = q;
    @(posedge wr_clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dout", 32'(data_out), 32'h00);
    @(negedge wr_clk);
    wr_rst = 1'b0;

    // Fill 0x01..0x10
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i + 1), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_empty", 32'(empty), 32'd0);

    // Overflow push is dropped
    cycle(1'b1, 8'hAA, 1'b0);
    check("ovf_count", 32'(count), 32'd16);
`ifdef FIFO_ERR_FLAGS_EN
    check("ovf_flag", 32'(ovf_err), 32'd1);
    check("udf_flag_clear", 32'(udf_err), 32'd0);
`endif

    // Drain, one word per pop
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check("drain_dout", 32'(data_out), 32'(i + 1));
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(count), 32'd0);

    // Underflow pop holds data_out
    cycle(1'b0, 8'h00, 1'b1);
    check("udf_dout", 32'(data_out), 32'h10);
    check("udf_count", 32'(count), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("udf_flag", 32'(udf_err), 32'd1);
`endif

    // Wrap-around: three rounds of 10 in / 10 out
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h20 + r * 16 + i), 1'b0);
      check("wrap_count", 32'(count), 32'd10);
      for (int i = 0; i < 10; i++) begin
        cycle(1'b0, 8'h00, 1'b1);
        check("wrap_dout", 32'(data_out), 32'(8'h20 + r * 16 + i));
      end
      check("wrap_empty", 32'(empty), 32'd1);
    end

    // Push + pop while full
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
    check("sim_full_pre", 32'(full), 32'd1);
    cycle(1'b1, 8'h55, 1'b1);
    check("sim_full_dout", 32'(data_out), 32'h80);
    check("sim_full_count", 32'(count), 32'd16);
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check("sim_full_drain", 32'(data_out), 32'(8'h81 + i));
    end
    cycle(1'b0, 8'h00, 1'b1);
    check("sim_full_last", 32'(data_out), 32'h55);
    check("sim_full_empty", 32'(empty), 32'd1);

    // Push + pop while empty: write only
    cycle(1'b1, 8'h66, 1'b1);
    check("sim_empty_count", 32'(count), 32'd1);
    check("sim_empty_dout", 32'(data_out), 32'h55);
    cycle(1'b0, 8'h00, 1'b1);
    check("sim_empty_read", 32'(data_out), 32'h66);
    check("sim_empty_after", 32'(empty), 32'd1);

    // Mid-operation asynchronous reset
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0);
    check("mid_pre_count", 32'(count), 32'd7);
    @(negedge wr_clk);
    #1;
    wr_rst = 1'b1;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_dout", 32'(data_out), 32'h00);
`ifdef FIFO_ERR_FLAGS_EN
    check("mid_rst_ovf", 32'(ovf_err), 32'd0);
    check("mid_rst_udf", 32'(udf_err), 32'd0);
`endif
    #1;
    wr_rst = 1'b0;
    cycle(1'b1, 8'h3C, 1'b0);
    check("post_rst_count", 32'(count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check("post_rst_dout", 32'(data_out), 32'h3C);
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
